bus_target_8088: RTL and testbench
==================================

Name: bus_target_8088

Overview:
Bus responder (target) for the 8088 local bus driven by processor_8088. Demultiplexes address from a[19:8] and ad[7:0] on ALE and decodes a memory or I/O window. Serves one-byte read/write cycles from a req/ack backing-store port, stretching the cycle with ready while the store is slow. One instance sits per memory or I/O region on the board-level bus (ROM, RAM, peripheral register banks).

Parameters:
BASE, 20'hF0000, window base address (compared after masking)
MASK, 20'hF0000, address bits compared for decode
IO_SPACE, 0, 1 = respond only when iom=1 (I/O); 0 = respond only when iom=0 (memory)
ADDR_W, 16, width of mem_addr (low bits of latched address)
TIMEOUT, 15, max cycles waiting for mem_ack before abort (range 1..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
a  in  20  address bus; only a[19:8] used
ad  inout  8  muxed address/data; addr[7:0] while ale=1, data otherwise
ale  in  1  address latch enable
rd_n  in  1  read strobe, active-low
wr_n  in  1  write strobe, active-low
iom  in  1  1 = I/O cycle, 0 = memory cycle
dtr  in  1  1 = CPU writes, 0 = CPU reads (valid during ale)
ready  out  1  0 = insert wait; 1 = target ready
sel  out  1  high while this target owns the current cycle
mem_req  out  1  backing-store request
mem_we  out  1  1 = write request
mem_addr  out  ADDR_W  latched address low bits
mem_wdata  out  8  captured write byte
mem_rdata  in  8  read data, valid with mem_ack
mem_ack  in  1  request complete; may assert in the same cycle as mem_req
bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst=0, async) values:
  - state IDLE; ready=1, sel=0, mem_req=0, mem_we=0, bus_err=0.
  - addr_q=0, data_q=0, wdata_q=0, wait counter=0; ad released (Z).
- Decode: hit = ((({a[19:8],ad} ^ BASE) & MASK) == 0) && (iom == IO_SPACE). Evaluated only on a clk edge with ale=1.
- States: IDLE, RD_REQ, RD_DRIVE, WR_CAP, WR_REQ, END.
- IDLE:
  - on edge with ale=1 and hit: addr_q <= {a[19:8],ad}; go to WR_CAP if dtr=1, else RD_REQ.
  - miss: stay IDLE; ad never driven.
- RD_REQ: mem_req=1, mem_we=0.
  - mem_ack=1: data_q <= mem_rdata, go to RD_DRIVE.
- RD_DRIVE: ad driven with data_q whenever rd_n=0; Z otherwise.
  - on edge with rd_n=1: exit. If ale=1 in that same cycle, decode the new cycle immediately (back-to-back); otherwise go to IDLE.
- WR_CAP: on edge with wr_n=0: wdata_q <= ad, go to WR_REQ.
- WR_REQ: mem_req=1, mem_we=1, mem_wdata=wdata_q.
  - mem_ack=1: go to END.
- END: wait for rd_n=1 and wr_n=1 on the same edge, then go to IDLE. The same-cycle ale rule from RD_DRIVE applies.
- Outputs:
  - ready = 0 only in RD_REQ and WR_REQ (combinational).
  - sel = 1 in every state except IDLE.
  - mem_addr = addr_q[ADDR_W-1:0].
- Latency: with mem_ack in the same cycle as mem_req, read data is on ad in the cycle after the first rd_n=0 cycle (the master's interm cycle), so zero wait states.
- Timeout:
  - the counter clears on entry to RD_REQ/WR_REQ and increments each cycle there.
  - reaching TIMEOUT without ack: abort, bus_err pulses one cycle.
  - read abort: data_q <= 8'hFF, go to RD_DRIVE. Write abort: write dropped, go to END.
  - mem_ack on the same cycle the counter reaches TIMEOUT: ack wins, no bus_err.
- Tri-state: ad is never driven while ale=1 or in any state other than RD_DRIVE.
- Reset mid-cycle: any asserted mem_req drops immediately; no partial write is committed by this block.
- ale=1 while not in IDLE/RD_DRIVE/END (protocol violation): ignored.

Decomposition:
- Shared package bus8088_pkg: state encoding localparams and the decode function (addr, base, mask).
- Natural sub-module: the timeout counter, reusing the existing counter module (width 8, inc/clr).

Test Plan:
- Zero-wait read: BASE=F0000, store acks immediately with 8'h5A; CPU reads F0010 -> mem_req for 1 cycle, mem_addr=16'h0010, ready stays 1, ad=8'h5A while rd_n=0, Z afterwards.
- Wait-state write: CPU writes 8'hC3 to F1234, store acks 3 cycles after mem_req -> ready low 3 cycles, mem_we=1, mem_wdata=8'hC3, mem_addr=16'h1234.
- Decode miss: CPU reads 80000 (memory) and I/O F0000 with IO_SPACE=0 -> sel=0, mem_req never asserts, ad never driven.
- Timeout: store never acks, TIMEOUT=4 -> ready low 4 cycles, single bus_err pulse, ad=8'hFF during rd_n=0.
- Back-to-back word fetch: CPU reads F0000 and F0001 in consecutive bus cycles -> two separate mem_req, bytes returned in order, no bus contention on ad during ale.
- Async reset asserted while in WR_REQ -> mem_req drops in the same cycle, ready=1, state IDLE; the next valid read completes normally.

Source files
------------

// File: rtl/bus8088_pkg.sv
// Shared definitions for 8088 local-bus targets: FSM encoding, counter width and
// the address-window decode.
package bus8088_pkg;

   localparam int unsigned AddrW = 20;
   localparam int unsigned CntW  = 8;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StRdReq   = 3'd1,
      StRdDrive = 3'd2,
      StWrCap   = 3'd3,
      StWrReq   = 3'd4,
      StEnd     = 3'd5
   } state_e;

   function automatic logic addr_hit(input logic [AddrW-1:0] addr,
                                     input logic [AddrW-1:0] base,
                                     input logic [AddrW-1:0] mask);
      return ((addr ^ base) & mask) == '0;
   endfunction

endpackage

// File: rtl/bus_target_8088_counter.sv
// Small up-counter with synchronous clear; clear has priority over increment.
module bus_target_8088_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [Width-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + Width'(1);
      end
   end

endmodule

// File: rtl/bus_target_8088.sv
// 8088 local-bus target: latches the address on ALE, decodes one memory or I/O window
// and serves single-byte cycles from a req/ack backing store, inserting waits via ready.
module bus_target_8088
   import bus8088_pkg::*;
#(
   parameter logic [19:0] BASE     = 20'hF0000,
   parameter logic [19:0] MASK     = 20'hF0000,
   parameter bit          IO_SPACE = 1'b0,
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [19:0]       a,
   inout  wire  [7:0]        ad,
   input  logic              ale,
   input  logic              rd_n,
   input  logic              wr_n,
   input  logic              iom,
   input  logic              dtr,
   output logic              ready,
   output logic              sel,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic              bus_err
);

   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

   state_e          state_q;
   logic [19:0]     addr_q;
   logic [7:0]      data_q;
   logic [7:0]      wdata_q;
   logic            bus_err_q;
   logic [CntW-1:0] wait_cnt;
   logic [19:0]     bus_addr;
   logic            hit;
   logic            in_req;
   logic            timeout;
   logic            start_next;
   state_e          start_state;
   logic            unused_bits;

   assign bus_addr    = {a[19:8], ad};
   assign hit         = addr_hit(bus_addr, BASE, MASK) && (iom == IO_SPACE);
   assign in_req      = (state_q == StRdReq) || (state_q == StWrReq);
   // Abort on the cycle the count reaches TIMEOUT; an ack in that cycle still wins.
   assign timeout     = in_req && !mem_ack && (wait_cnt == TimeoutLast);
   assign start_next  = ale && hit;
   assign start_state = dtr ? StWrCap : StRdReq;
   assign unused_bits = ^{a[7:0], addr_q};

   bus_target_8088_counter #(
      .Width(CntW)
   ) u_wait_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (!in_req),
      .inc  (in_req),
      .count(wait_cnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         data_q    <= '0;
         wdata_q   <= '0;
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_next) begin
                  addr_q  <= bus_addr;
                  state_q <= start_state;
               end
            end
            StRdReq: begin
               if (mem_ack) begin
                  data_q  <= mem_rdata;
                  state_q <= StRdDrive;
               end else if (timeout) begin
                  data_q    <= 8'hFF;
                  bus_err_q <= 1'b1;
                  state_q   <= StRdDrive;
               end
            end
            StRdDrive: begin
               if (rd_n) begin
                  if (start_next) begin
                     addr_q  <= bus_addr;
                     state_q <= start_state;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StWrCap: begin
               if (!wr_n) begin
                  wdata_q <= ad;
                  state_q <= StWrReq;
               end
            end
            StWrReq: begin
               if (mem_ack) begin
                  state_q <= StEnd;
               end else if (timeout) begin
                  bus_err_q <= 1'b1;
                  state_q   <= StEnd;
               end
            end
            StEnd: begin
               if (rd_n && wr_n) begin
                  if (start_next) begin
                     addr_q  <= bus_addr;
                     state_q <= start_state;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ready     = !(in_req && !mem_ack);
   assign sel       = (state_q != StIdle);
   assign mem_req   = in_req;
   assign mem_we    = (state_q == StWrReq);
   assign mem_addr  = addr_q[ADDR_W-1:0];
   assign mem_wdata = wdata_q;
   assign bus_err   = bus_err_q;

   // The master owns ad during ALE, so never drive it then.
   assign ad = (state_q == StRdDrive && !rd_n && !ale) ? data_q : 8'bz;

endmodule

// File: tb/tb_bus_target_8088.sv
// Directed bench for bus_target_8088: a vector table of single bus cycles plus
// hand-written back-to-back and mid-cycle reset sequences.
module tb_bus_target_8088;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] a;
   wire  [7:0]  ad;
   logic [7:0]  ad_drv;
   logic        ad_oe;
   logic        ale, rd_n, wr_n, iom, dtr;
   logic        ready, sel, mem_req, mem_we, mem_ack, bus_err;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;

   assign ad = ad_oe ? ad_drv : 8'bz;

   always #5 clk = ~clk;

   bus_target_8088 #(
      .BASE    (20'hF0000),
      .MASK    (20'hF0000),
      .IO_SPACE(1'b0),
      .ADDR_W  (16),
      .TIMEOUT (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .ad       (ad),
      .ale      (ale),
      .rd_n     (rd_n),
      .wr_n     (wr_n),
      .iom      (iom),
      .dtr      (dtr),
      .ready    (ready),
      .sel      (sel),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ack  (mem_ack),
      .bus_err  (bus_err)
   );

   // Backing store: acks when the request has been up for ack_dly cycles.
   int         ack_dly;
   int         req_age;
   logic [7:0] store_data;

   always @(posedge clk or negedge rst) begin
      if (!rst) req_age <= 0;
      else      req_age <= mem_req ? req_age + 1 : 0;
   end
   assign mem_ack   = mem_req && (req_age == ack_dly);
   assign mem_rdata = store_data;

   // Negedge monitor.
   logic       mon_en;
   int         n_rlow, n_req, n_err, n_ack, n_drv, n_bad;
   logic       sel_seen, ack_we;
   logic [15:0] ack_addr;
   logic [7:0] ack_wdata, rd_val;

   always @(negedge clk) begin
      if (mon_en) begin
         if (!ready) n_rlow++;
         if (mem_req) n_req++;
         if (bus_err) n_err++;
         if (sel) sel_seen = 1'b1;
         if (mem_req && mem_ack) begin
            n_ack++;
            ack_addr  = mem_addr;
            ack_we    = mem_we;
            ack_wdata = mem_wdata;
         end
         if (ad_oe) begin
            if (ad !== ad_drv) n_bad++;
         end else if (ad !== 8'hzz) begin
            n_drv++;
            rd_val = ad;
            if (rd_n || ale) n_bad++;
         end
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic mon_clear();
      n_rlow = 0; n_req = 0; n_err = 0; n_ack = 0; n_drv = 0; n_bad = 0;
      sel_seen = 1'b0; ack_we = 1'b0; ack_addr = '0; ack_wdata = '0; rd_val = '0;
   endtask

   typedef struct {
      logic [19:0] addr;
      logic        iom;
      logic        wr;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
      int          ack_dly;
      logic        hit;
      int          rlow;
      int          req;
      int          err;
      int          ack;
      logic [7:0]  exp_rd;
   } vec_t;

   vec_t vecs[11];

   task automatic run_vec(input vec_t v, input string tag);
      logic seen;
      logic done;
      mon_clear();
      mon_en     = 1'b1;
      ack_dly    = v.ack_dly;
      store_data = v.rdata;
      a = v.addr; ad_drv = v.addr[7:0]; ad_oe = 1'b1; ale = 1'b1; iom = v.iom; dtr = v.wr;
      @(posedge clk); #1;
      ale = 1'b0;
      if (v.wr) begin
         ad_drv = v.wdata;
         wr_n   = 1'b0;
      end else begin
         ad_oe = 1'b0;
         rd_n  = 1'b0;
      end
      seen = 1'b0;
      done = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1;
         else if (seen || (!sel && n >= 1)) done = 1'b1;
         if (!done) begin
            @(posedge clk); #1;
         end
      end
      check({tag, "_completed"}, done, 1'b1);
      @(posedge clk); #1;
      rd_n = 1'b1; wr_n = 1'b1; ad_oe = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      mon_en = 1'b0;
      check({tag, "_sel_seen"}, sel_seen, v.hit);
      check({tag, "_ready_low"}, n_rlow, v.rlow);
      check({tag, "_req_cycles"}, n_req, v.req);
      check({tag, "_bus_err"}, n_err, v.err);
      check({tag, "_acks"}, n_ack, v.ack);
      check({tag, "_ad_drive"}, n_drv, (v.hit && !v.wr) ? 1 : 0);
      check({tag, "_ad_contention"}, n_bad, 0);
      check({tag, "_idle_after"}, sel, 1'b0);
      if (v.ack != 0) begin
         check({tag, "_mem_addr"}, ack_addr, v.addr[15:0]);
         check({tag, "_mem_we"}, ack_we, v.wr);
         if (v.wr) check({tag, "_mem_wdata"}, ack_wdata, v.wdata);
      end
      if (v.hit && !v.wr) check({tag, "_read_data"}, rd_val, v.exp_rd);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //          addr       iom   wr    wdata  rdata  dly  hit  rlow req err ack exp_rd
      vecs[0]  = '{20'hF0010, 1'b0, 1'b0, 8'h00, 8'h5A, 0,   1'b1, 0, 1, 0, 1, 8'h5A};
      vecs[1]  = '{20'hF1234, 1'b0, 1'b1, 8'hC3, 8'h00, 3,   1'b1, 3, 4, 0, 1, 8'h00};
      vecs[2]  = '{20'h80000, 1'b0, 1'b0, 8'h00, 8'h11, 0,   1'b0, 0, 0, 0, 0, 8'h00};
      vecs[3]  = '{20'hF0000, 1'b1, 1'b0, 8'h00, 8'h11, 0,   1'b0, 0, 0, 0, 0, 8'h00};
      vecs[4]  = '{20'hF00AB, 1'b0, 1'b0, 8'h00, 8'h12, 255, 1'b1, 4, 4, 1, 0, 8'hFF};
      vecs[5]  = '{20'hF0055, 1'b0, 1'b1, 8'h77, 8'h00, 255, 1'b1, 4, 4, 1, 0, 8'h00};
      vecs[6]  = '{20'hFFFFF, 1'b0, 1'b0, 8'h00, 8'h3C, 2,   1'b1, 2, 3, 0, 1, 8'h3C};
      vecs[7]  = '{20'hF0100, 1'b0, 1'b0, 8'h00, 8'h96, 3,   1'b1, 3, 4, 0, 1, 8'h96};
      vecs[8]  = '{20'hF8000, 1'b0, 1'b1, 8'h00, 8'h00, 0,   1'b1, 0, 1, 0, 1, 8'h00};
      vecs[9]  = '{20'hEFFFF, 1'b0, 1'b0, 8'h00, 8'h44, 0,   1'b0, 0, 0, 0, 0, 8'h00};
      vecs[10] = '{20'hF0000, 1'b1, 1'b1, 8'hAA, 8'h00, 0,   1'b0, 0, 0, 0, 0, 8'h00};

      rst = 1'b0; a = '0; ad_drv = '0; ad_oe = 1'b0; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
      iom = 1'b0; dtr = 1'b0; ack_dly = 0; store_data = '0; mon_en = 1'b0;
      mon_clear();

      #12;
      check("rst_ready", ready, 1'b1);
      check("rst_sel", sel, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_bus_err", bus_err, 1'b0);
      check("rst_mem_addr", mem_addr, 16'h0000);
      check("rst_mem_wdata", mem_wdata, 8'h00);
      check("rst_ad_released", (ad === 8'hzz), 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Back-to-back reads: the second ALE arrives in the same cycle rd_n rises.
      mon_clear();
      mon_en = 1'b1; ack_dly = 0; store_data = 8'h11;
      a = 20'hF0000; ad_drv = 8'h00; ad_oe = 1'b1; ale = 1'b1; iom = 1'b0; dtr = 1'b0;
      @(posedge clk); #1;
      ale = 1'b0; ad_oe = 1'b0; rd_n = 1'b0;
      @(negedge clk);
      check("b2b_req0", mem_req, 1'b1);
      check("b2b_addr0", mem_addr, 16'h0000);
      @(posedge clk); #1;
      store_data = 8'h22;
      @(negedge clk);
      check("b2b_data0", ad, 8'h11);
      @(posedge clk); #1;
      rd_n = 1'b1; ale = 1'b1; a = 20'hF0001; ad_drv = 8'h01; ad_oe = 1'b1;
      @(negedge clk);
      check("b2b_ale_no_contention", ad, 8'h01);
      check("b2b_sel_held", sel, 1'b1);
      @(posedge clk); #1;
      ale = 1'b0; ad_oe = 1'b0; rd_n = 1'b0;
      @(negedge clk);
      check("b2b_req1", mem_req, 1'b1);
      check("b2b_addr1", mem_addr, 16'h0001);
      @(posedge clk); #1;
      @(negedge clk);
      check("b2b_data1", ad, 8'h22);
      @(posedge clk); #1;
      rd_n = 1'b1;
      @(negedge clk);
      check("b2b_released", (ad === 8'hzz), 1'b1);
      @(posedge clk); #1;
      mon_en = 1'b0;
      check("b2b_req_cycles", n_req, 2);
      check("b2b_drive_cycles", n_drv, 2);
      check("b2b_contention", n_bad, 0);
      check("b2b_idle_after", sel, 1'b0);

      // Async reset while a write waits on the store.
      ack_dly = 255;
      a = 20'hF4321; ad_drv = 8'h21; ad_oe = 1'b1; ale = 1'b1; iom = 1'b0; dtr = 1'b1;
      @(posedge clk); #1;
      ale = 1'b0; ad_drv = 8'hE7; wr_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmid_req_before", mem_req, 1'b1);
      check("rstmid_we_before", mem_we, 1'b1);
      check("rstmid_ready_before", ready, 1'b0);
      #2 rst = 1'b0;
      #1;
      check("rstmid_req_dropped", mem_req, 1'b0);
      check("rstmid_we_dropped", mem_we, 1'b0);
      check("rstmid_ready", ready, 1'b1);
      check("rstmid_sel", sel, 1'b0);
      check("rstmid_mem_addr", mem_addr, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b1; wr_n = 1'b1; ad_oe = 1'b0;
      @(posedge clk); #1;
      run_vec('{20'hF0077, 1'b0, 1'b0, 8'h00, 8'hB4, 1, 1'b1, 1, 2, 0, 1, 8'hB4}, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
